// File: rtl/aes_cmac.sv
// AES-128 ECB + RFC 4493 CMAC engine streaming blocks from a dual-port BRAM.
// Two iterative AES cores share one 12-cycle block period.

module aes_core #(
    parameter logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [5:0]   cntr,
    input  logic [127:0] din,
    output logic [127:0] dout
);
    logic [127:0] st, rk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            y = y >> 1;
            x = xt(x);
        end
        return r;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, r;
        p = a; r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [5:0] c);
        case (c)
            6'd2:    return 8'h02;
            6'd3:    return 8'h04;
            6'd4:    return 8'h08;
            6'd5:    return 8'h10;
            6'd6:    return 8'h20;
            6'd7:    return 8'h40;
            6'd8:    return 8'h80;
            6'd9:    return 8'h1b;
            6'd10:   return 8'h36;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
            ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] rnd(input logic [127:0] s, input logic [127:0] k,
                                         input logic last);
        logic [127:0] b, sr, mc;
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++)
            b[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = b[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return (last ? sr : mc) ^ k;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= '0;
            rk <= '0;
        end else if (cntr == 6'd1) begin
            st <= din ^ KEY;
            rk <= expand(KEY, 8'h01);
        end else if (cntr >= 6'd2 && cntr <= 6'd10) begin
            st <= rnd(st, rk, 1'b0);
            rk <= expand(rk, rcon(cntr));
        end
    end

    assign dout = rnd(st, rk, 1'b1);
endmodule

module aes_cmac #(
    parameter logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  len,
    input  logic [127:0] messIn,
    input  logic [127:0] cmacIn,
    output logic [8:0]   messAddra,
    output logic [8:0]   cmacAddra,
    output logic [127:0] encrypted,
    output logic         cmacDone,
    output logic [127:0] tag,
    output logic [5:0]   cntr
);
    typedef enum logic {RUN, DONE} state_t;
    state_t st, st_nx;

    logic [25:0]  period, n, pn;
    logic [6:0]   r;
    logic [127:0] x, k1, k2, pad, blk, cmac_din, ecb_out, cmac_out;

    function automatic logic [127:0] dbl(input logic [127:0] v);
        return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    assign r  = len[6:0];
    assign n  = (len == 32'd0) ? 26'd1 : {1'b0, len[31:7]} + {25'd0, |r};
    assign pn = period + 26'd1;
    assign k2 = dbl(k1);
    // keep the top r bits, then the 10* padding marker at bit 127-r
    assign pad = (cmacIn & ~({128{1'b1}} >> r)) | ({1'b1, 127'd0} >> r);

    always_comb begin
        blk = cmacIn;
        if (period == n)
            blk = (r == 7'd0 && len != 32'd0) ? (cmacIn ^ k1) : (pad ^ k2);
        cmac_din = (period == 26'd0) ? 128'h0 : (x ^ blk);
    end

    aes_core #(.KEY(KEY)) u_ecb (
        .clk(clk), .reset(reset), .cntr(cntr), .din(messIn), .dout(ecb_out)
    );
    aes_core #(.KEY(KEY)) u_cmac (
        .clk(clk), .reset(reset), .cntr(cntr), .din(cmac_din), .dout(cmac_out)
    );

    always_comb begin
        st_nx = st;
        if (st == RUN && cntr == 6'd11 && period == n)
            st_nx = DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= RUN;
        else       st <= st_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntr      <= '0;
            period    <= '0;
            messAddra <= '0;
            cmacAddra <= '0;
            encrypted <= '0;
            tag       <= '0;
            cmacDone  <= 1'b0;
            x         <= '0;
            k1        <= '0;
        end else if (st == RUN) begin
            cntr <= (cntr == 6'd11) ? 6'd0 : cntr + 6'd1;
            if (cntr == 6'd11) begin
                if (period < n)
                    encrypted <= ecb_out;
                if (period == 26'd0)
                    k1 <= dbl(cmac_out);
                else
                    x <= cmac_out;
                if (period == n) begin
                    tag      <= cmac_out;
                    cmacDone <= 1'b1;
                end else begin
                    period    <= pn;
                    cmacAddra <= period[8:0];
                    if (pn < n)
                        messAddra <= pn[8:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_cmac.sv
// Directed-vector bench for aes_cmac using RFC 4493 / SP800-38A values.
// Models the message BRAM with 1-cycle synchronous read ports.

module tb_aes_cmac;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  len = '0;
    logic [127:0] messIn, cmacIn;
    logic [8:0]   messAddra, cmacAddra;
    logic [127:0] encrypted, tag;
    logic         cmacDone;
    logic [5:0]   cntr;

    int compared = 0;
    int mismatched = 0;

    logic [127:0] mem [0:511];
    logic [127:0] ecb [0:3];

    typedef struct {
        logic [31:0]  len;
        logic [127:0] tag;
        int           done_edge;
        int           n;
    } vec_t;
    vec_t vt [4];

    aes_cmac dut (
        .clk(clk), .reset(reset), .len(len),
        .messIn(messIn), .cmacIn(cmacIn),
        .messAddra(messAddra), .cmacAddra(cmacAddra),
        .encrypted(encrypted), .cmacDone(cmacDone),
        .tag(tag), .cntr(cntr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        messIn <= mem[messAddra];
        cmacIn <= mem[cmacAddra];
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit chk_k1);
        int p;
        reset = 1'b1;
        len = v.len;
        @(negedge clk);
        chk("rst encrypted", encrypted, 128'h0);
        chk("rst tag", tag, 128'h0);
        chk("rst done", {127'h0, cmacDone}, 128'h0);
        chk("rst addrs", {110'h0, messAddra, cmacAddra}, 128'h0);
        chk("rst cntr", {122'h0, cntr}, 128'h0);
        reset = 1'b0;
        for (int e = 1; e <= v.done_edge + 12; e++) begin
            @(posedge clk);
            #1;
            p = e / 12;
            if (e == 7)
                chk("cntr e7", {122'h0, cntr}, 128'd7);
            if (e == 11)
                chk("encrypted e11", encrypted, 128'h0);
            if (e % 12 == 0 && p <= v.n)
                chk($sformatf("encrypted p%0d", p - 1), encrypted, ecb[p - 1]);
            if (e % 12 == 6 && p <= v.n) begin
                chk($sformatf("messAddra p%0d", p), {119'h0, messAddra},
                    128'((p < v.n) ? p : v.n - 1));
                chk($sformatf("cmacAddra p%0d", p), {119'h0, cmacAddra},
                    128'((p == 0) ? 0 : p - 1));
            end
            if (e == 12 && chk_k1) begin
                chk("K1", dut.k1, 128'hfbeed618357133667c85e08f7236a8de);
                chk("K2", dut.k2, 128'hf7ddac306ae266ccf90bc11ee46d513b);
            end
            if (e == v.done_edge - 1) begin
                chk("done early", {127'h0, cmacDone}, 128'h0);
                chk("tag early", tag, 128'h0);
            end
            if (e == v.done_edge) begin
                chk("done edge", {127'h0, cmacDone}, 128'h1);
                chk("tag", tag, v.tag);
            end
            if (e == v.done_edge + 11) begin
                chk("done hold", {127'h0, cmacDone}, 128'h1);
                chk("tag hold", tag, v.tag);
                chk("cntr hold", {122'h0, cntr}, 128'h0);
                chk("messAddra hold", {119'h0, messAddra}, 128'(v.n - 1));
                chk("encrypted hold", encrypted, ecb[v.n - 1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        mem[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        mem[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        mem[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        ecb[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        ecb[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        ecb[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        ecb[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;

        vt[0] = '{32'd128, 128'h070a16b46b4d4144f79bdd9dd04a287c, 24, 1};
        vt[1] = '{32'd0,   128'hbb1d6929e95937287fa37d129b756746, 24, 1};
        vt[2] = '{32'd320, 128'hdfa66747de9ae63030ca32611497c827, 48, 3};
        vt[3] = '{32'd512, 128'h51f0bebf7e3b9d92fc49741779363cfe, 60, 4};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++)
            run_vec(vt[i], i == 0);

        // abort a len=512 run at edge 30, then rerun it from scratch
        reset = 1'b1;
        len = 32'd512;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("pre-abort encrypted", encrypted, ecb[1]);
        chk("pre-abort messAddra", {119'h0, messAddra}, 128'd2);
        reset = 1'b1;
        #1;
        chk("abort encrypted", encrypted, 128'h0);
        chk("abort addrs", {110'h0, messAddra, cmacAddra}, 128'h0);
        chk("abort cntr", {122'h0, cntr}, 128'h0);
        chk("abort done/tag", {cmacDone, tag[126:0]}, 128'h0);
        run_vec(vt[3], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/aes_cmac.md
# aes_cmac

AES-128 engine that streams a message out of a dual-port 512×128 block RAM and does two jobs on it. It produces the ECB ciphertext of every 128-bit message block. It also computes the RFC 4493 AES-CMAC tag over the whole message. It sits between the message BRAM (`ram`, read-only here) and downstream consumers of ciphertext and tag.

## Interface
- KEY, 128'h2b7e151628aed2a6abf7158809cf4f3c, AES-128 cipher key; fixed at elaboration.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- len  in  32  message length in bits; sampled continuously; must be stable while reset is low.
- messIn  in  128  RAM port A read data for address messAddra; 1-cycle synchronous read latency.
- cmacIn  in  128  RAM port B read data for address cmacAddra; 1-cycle latency.
- messAddra  out  9  ECB lane block address.
- cmacAddra  out  9  CMAC lane block address.
- encrypted  out  128  AES_KEY of the most recently completed ECB block.
- cmacDone  out  1  high once the tag is final; sticky until reset.
- tag  out  128  CMAC tag; 0 until cmacDone.
- cntr  out  6  cycle index within the current 12-cycle block period (0..11).

## Operation
- **Block count.** n = ceil(len/128), with n = 1 when len = 0. Word i holds message bytes 16i..16i+15, with byte 0 in bits [127:120]. Blocks beyond index 511 are unsupported.
- **AES core.** Iterative, one round per cycle. On-the-fly key schedule restarts from KEY for each block. S-box may be computed (GF(2^8) inverse + affine) or tabulated.
- **Lanes.** Two instances of the same core run in lockstep on a common block period.
- **ECB lane.**
  - In period p (p = 0..n-1), drives messAddra = p and encrypts messIn.
  - At the end of period p, `encrypted` <= AES(M_p).
  - Idle in period n.
- **CMAC lane, period 0.** Computes L = AES(0^128). Derives K1 = (L<<1) ^ (msb(L) ? 0x87 : 0) and K2 likewise from K1. X = 0. cmacAddra = 0.
- **CMAC lane, period p = 1..n.**
  - Drives cmacAddra = p-1.
  - For block index j = p-1 < n-1: X <= AES(X ^ cmacIn).
  - Last block (j = n-1), complete (len != 0 and len%128 == 0): X <= AES(X ^ cmacIn ^ K1).
  - Last block, incomplete:
    - Let r = len%128 (or 0 for empty).
    - Keep the top r bits of cmacIn.
    - Set bit 127-r to 1 and zero the rest.
    - X <= AES(X ^ padded ^ K2).
- **FSM.** RUN → DONE.
  - RUN covers periods 0..n.
  - At the end of period n: tag <= X, cmacDone <= 1, enter DONE.
- **DONE.** All outputs hold (addresses stay n-1, cntr stays 0). Exit only via reset.

## Timing
- **Block period.** 12 cycles, tracked by cntr.
  - cntr = 0: address presented.
  - cntr = 1: RAM data valid; state <= data ^ round-key 0.
  - cntr = 2..11: rounds 1..10; round 10 omits MixColumns.
  - The result registers on the edge that ends cntr = 11.
- **Reset values.** encrypted = 0, tag = 0, cmacDone = 0, messAddra = 0, cmacAddra = 0, cntr = 0, FSM = RUN/period 0.
- **Cycle 0.** The first rising edge after reset deasserts executes cntr = 0 of period 0.
- **encrypted timing.** Block p ciphertext appears 12(p+1) edges after reset release.
- **cmacDone timing.** Rises 12(n+1) edges after reset release (n = 267, len = 34176: 3216 edges).
- **Reset mid-operation.** Aborts immediately and asynchronously to the reset values. Restarts from period 0 after release.
- **Addresses.** Change only at the cntr 11→0 boundary, so RAM outputs are stable during cntr = 1.
- **RAM contract.** Dual-port, synchronous read, 1-cycle latency, writes disabled.

## Test plan
- **Subkeys / ECB.** len = 128, word0 = 6bc1bee22e409f96e93d7e117393172a.
  - Internal K1 = fbeed618357133667c85e08f7236a8de, K2 = f7ddac306ae266ccf90bc11ee46d513b.
  - encrypted = 3ad77bb40d7a3660a89ecaf32466ef97 at edge 12.
- **Single complete block.** Same RAM, len = 128 → tag = 070a16b46b4d4144f79bdd9dd04a287c, cmacDone at edge 24.
- **Empty message.** len = 0 → tag = bb1d6929e95937287fa37d129b756746; cmacAddra stays 0; cmacDone at edge 24.
- **Padded last block.** RFC 4493 40-byte message, len = 320 → tag = dfa66747de9ae63030ca32611497c827; cmacDone at edge 48.
- **Multi-block complete.** RFC 4493 64-byte message, len = 512 → tag = 51f0bebf7e3b9d92fc49741779363cfe; messAddra sequence 0,1,2,3; cmacAddra lags by one period.
- **Reset mid-run.** Assert reset at edge 30 of the len = 512 run → all outputs 0 immediately. After release, the full run repeats with an identical tag and timing.
